ahblite_lvds_bridge_mc: RTL and testbench

//  AHB-Lite slave exposing NUM_EU LVDS receive channels to the CPU: packed per-channel state words,
//  a write-1-to-pulse clear register and one buffer window per channel. Parametrised in channel count,

---
 rtl/ahblite_lvds_bridge_mc.sv | 198 +++++++++++++++++++
 tb/tb_ahblite_lvds_bridge_mc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_lvds_bridge_mc.sv
// AHB-Lite slave bridging CPU accesses to NUM_EU LVDS receive channels.
// Register block: packed RX state words, a write-1-to-pulse clear register
// and a read-only INFO word. Buffer window: one read-only window per channel,
// served with a configurable read latency. Illegal accesses get a two-cycle
// ERROR response. NUM_EU is expected to stay within 1..8 and RD_WAIT within 0..3.
module ahblite_lvds_bridge_mc #(
    parameter int          NUM_EU     = 4,
    parameter int          BUF_ADDR_W = 9,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter logic [31:0] BUF_BASE   = 32'h4001_0000,
    parameter int          RD_WAIT    = 1
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic                    HREADY,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    output logic [31:0]             HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [BUF_ADDR_W-1:0]   EU_BUF_ADDR,
    input  logic [32*NUM_EU-1:0]    EU_BUF_DATA,
    input  logic [8*NUM_EU-1:0]     EU_STATE,
    output logic [NUM_EU-1:0]       EU_SEL,
    output logic [NUM_EU-1:0]       RX_STATE_CLEAR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REG = 3'd1,
        S_RD_BUF = 3'd2,
        S_RD_OUT = 3'd3,
        S_WR     = 3'd4,
        S_ERR1   = 3'd5,
        S_ERR2   = 3'd6
    } state_t;

    // Register offsets (HADDR[3:2])
    localparam logic [1:0] REG_STATUS0 = 2'd0;
    localparam logic [1:0] REG_STATUS1 = 2'd1;
    localparam logic [1:0] REG_CLEAR   = 2'd2;
    localparam logic [1:0] REG_INFO    = 2'd3;

    state_t                 state_q, state_d;
    logic [31:0]            hrdata_q, hrdata_d;
    logic [BUF_ADDR_W-1:0]  buf_addr_q, buf_addr_d;
    logic [NUM_EU-1:0]      sel_q, sel_d;
    logic [NUM_EU-1:0]      clear_q, clear_d;
    logic [1:0]             wait_q, wait_d;
    logic [1:0]             reg_sel_q, reg_sel_d;
    logic [2:0]             chan_q, chan_d;

    // Channel data padded out to eight slots so absent channels read as zero
    // and a 3-bit channel index always lands inside the array.
    logic [7:0]             st_arr  [8];
    logic [31:0]            buf_arr [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ch
            if (gi < NUM_EU) begin : g_on
                assign st_arr[gi]  = EU_STATE[8*gi +: 8];
                assign buf_arr[gi] = EU_BUF_DATA[32*gi +: 32];
            end else begin : g_off
                assign st_arr[gi]  = 8'h00;
                assign buf_arr[gi] = 32'h0;
            end
        end
    endgenerate

    // Address-phase decode
    logic        accept;
    logic        size_ok;
    logic        reg_hit;
    logic        buf_hit;
    logic [31:0] buf_off;
    logic [31:0] buf_chan_w;
    logic [31:0] reg_word;

    assign accept     = HSEL & HREADY & HTRANS[1] &
                        ((state_q == S_IDLE) | (state_q == S_WR) | (state_q == S_RD_OUT));
    assign size_ok    = (HSIZE == 3'b010);
    assign reg_hit    = (HADDR[31:4] == BASE_ADDR[31:4]);
    assign buf_off    = HADDR - BUF_BASE;
    assign buf_chan_w = buf_off >> (BUF_ADDR_W + 2);
    assign buf_hit    = (HADDR >= BUF_BASE) && (buf_chan_w < 32'(NUM_EU));

    // Select the register word latched during the RD_REG cycle
    always_comb begin
        reg_word = 32'h0;
        case (reg_sel_q)
            REG_STATUS0: reg_word = {st_arr[0], st_arr[1], st_arr[2], st_arr[3]};
            REG_STATUS1: reg_word = {st_arr[4], st_arr[5], st_arr[6], st_arr[7]};
            REG_INFO:    reg_word = {16'h0, 8'(BUF_ADDR_W), 8'(NUM_EU)};
            default:     reg_word = 32'h0;
        endcase
    end

    // Next-state and datapath: transfer acceptance, wait-state counting, capture
    always_comb begin
        state_d    = state_q;
        hrdata_d   = hrdata_q;
        buf_addr_d = buf_addr_q;
        sel_d      = sel_q;
        clear_d    = '0;
        wait_d     = wait_q;
        reg_sel_d  = reg_sel_q;
        chan_d     = chan_q;

        case (state_q)
            S_RD_REG: begin
                hrdata_d = reg_word;
                state_d  = S_RD_OUT;
            end
            S_RD_BUF: begin
                if (wait_q == 2'(RD_WAIT)) begin
                    hrdata_d = buf_arr[chan_q];
                    state_d  = S_RD_OUT;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            S_ERR2: state_d = S_IDLE;
            default: begin
                // IDLE, WR and RD_OUT all finish their data phase this cycle
                // and may overlap the next address phase.
                if (state_q == S_WR) begin
                    clear_d = HWDATA[NUM_EU-1:0];
                end
                if (state_q == S_RD_OUT) begin
                    sel_d = '0;
                end
                state_d = S_IDLE;
                if (accept) begin
                    if (!size_ok) begin
                        state_d = S_ERR1;
                    end else if (reg_hit) begin
                        if (HWRITE) begin
                            state_d = (HADDR[3:2] == REG_CLEAR) ? S_WR : S_ERR1;
                        end else if (HADDR[3:2] == REG_CLEAR) begin
                            state_d = S_ERR1;
                        end else begin
                            state_d   = S_RD_REG;
                            reg_sel_d = HADDR[3:2];
                        end
                    end else if (buf_hit && !HWRITE) begin
                        state_d    = S_RD_BUF;
                        wait_d     = 2'd0;
                        chan_d     = buf_chan_w[2:0];
                        buf_addr_d = HADDR[BUF_ADDR_W+1:2];
                        sel_d      = NUM_EU'(1) << buf_chan_w[2:0];
                    end else begin
                        state_d = S_ERR1;
                    end
                end
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            hrdata_q   <= 32'h0;
            buf_addr_q <= '0;
            sel_q      <= '0;
            clear_q    <= '0;
            wait_q     <= 2'd0;
            reg_sel_q  <= 2'd0;
            chan_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            hrdata_q   <= hrdata_d;
            buf_addr_q <= buf_addr_d;
            sel_q      <= sel_d;
            clear_q    <= clear_d;
            wait_q     <= wait_d;
            reg_sel_q  <= reg_sel_d;
            chan_q     <= chan_d;
        end
    end

    assign HRDATA         = hrdata_q;
    assign HREADYOUT      = !((state_q == S_RD_REG) || (state_q == S_RD_BUF) || (state_q == S_ERR1));
    assign HRESP          = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign EU_BUF_ADDR    = buf_addr_q;
    assign EU_SEL         = sel_q;
    assign RX_STATE_CLEAR = clear_q;

    // HTRANS[0] (SEQ vs NONSEQ) and clear bits above NUM_EU carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{HTRANS[0], HWDATA[31:NUM_EU]};

endmodule

// File: tb/tb_ahblite_lvds_bridge_mc.sv
// Directed bench for ahblite_lvds_bridge_mc (NUM_EU=4, BUF_ADDR_W=9, RD_WAIT=2).
module tb_ahblite_lvds_bridge_mc;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] BUFB = 32'h4001_0000;

    logic         clk = 1'b0;
    logic         hreset;
    logic         hsel;
    logic         hready;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize;
    logic [31:0]  hwdata;
    logic [31:0]  hrdata;
    logic         hreadyout;
    logic         hresp;
    logic [8:0]   eu_buf_addr;
    logic [127:0] eu_buf_data;
    logic [31:0]  eu_state;
    logic [3:0]   eu_sel;
    logic [3:0]   rx_state_clear;

    int vectors = 0;
    int miscompares = 0;

    // Pulse / select observers
    int          pulse_cnt;
    logic [3:0]  pulse_or;
    logic [15:0] pulse_log;
    logic [3:0]  sel_seen;

    // Transaction results
    logic [31:0] rd;
    logic        r0;
    logic        r1;
    int          wt;

    always #5 clk = ~clk;

    assign hready = hreadyout;

    ahblite_lvds_bridge_mc #(
        .NUM_EU     (4),
        .BUF_ADDR_W (9),
        .BASE_ADDR  (BASE),
        .BUF_BASE   (BUFB),
        .RD_WAIT    (2)
    ) dut (
        .HCLK           (clk),
        .HRESET         (hreset),
        .HSEL           (hsel),
        .HREADY         (hready),
        .HADDR          (haddr),
        .HTRANS         (htrans),
        .HWRITE         (hwrite),
        .HSIZE          (hsize),
        .HWDATA         (hwdata),
        .HRDATA         (hrdata),
        .HREADYOUT      (hreadyout),
        .HRESP          (hresp),
        .EU_BUF_ADDR    (eu_buf_addr),
        .EU_BUF_DATA    (eu_buf_data),
        .EU_STATE       (eu_state),
        .EU_SEL         (eu_sel),
        .RX_STATE_CLEAR (rx_state_clear)
    );

    always @(negedge clk) begin
        if (rx_state_clear != 4'h0) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_or  = pulse_or | rx_state_clear;
            pulse_log = {pulse_log[11:0], rx_state_clear};
        end
        if (!hreadyout && !hresp) begin
            sel_seen = sel_seen | eu_sel;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        pulse_cnt = 0;
        pulse_or  = 4'h0;
        pulse_log = 16'h0;
        sel_seen  = 4'h0;
    endtask

    task automatic idle(input int n);
        hsel   = 1'b0;
        htrans = 2'b00;
        repeat (n) @(negedge clk);
    endtask

    // One single transfer; returns at the negedge of its final data-phase cycle
    // so a following call overlaps its address phase with that cycle.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic resp_first, output logic resp_last, output int waits);
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        hsel   = 1'b1;
        htrans = 2'b10;
        @(posedge clk);
        #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        if (wr) hwdata = wdata;
        waits = 0;
        @(negedge clk);
        resp_first = hresp;
        while (!hreadyout && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        rdata     = hrdata;
        resp_last = hresp;
        $display("xfer addr=%h wr=%0d size=%0d wdata=%h rdata=%h resp=%0d/%0d waits=%0d",
                 addr, wr, size, wdata, rdata, resp_first, resp_last, waits);
    endtask

    initial begin
        hreset      = 1'b1;
        hsel        = 1'b0;
        haddr       = 32'h0;
        htrans      = 2'b00;
        hwrite      = 1'b0;
        hsize       = 3'b010;
        hwdata      = 32'h0;
        eu_state    = {8'h44, 8'h33, 8'h22, 8'h11};
        eu_buf_data = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        clr_mon();

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_hrdata", hrdata, 32'h0);
        check_val("rst_hreadyout", 32'(hreadyout), 32'd1);
        check_val("rst_hresp", 32'(hresp), 32'd0);
        check_val("rst_buf_addr", 32'(eu_buf_addr), 32'd0);
        check_val("rst_eu_sel", 32'(eu_sel), 32'd0);
        check_val("rst_clear", 32'(rx_state_clear), 32'd0);
        hreset = 1'b0;

        // Register reads: one wait state each
        xfer(BASE + 32'h0, 1'b0, 3'b010, 32'h0, rd, r0, r1, wt);
        check_val("status0_data", rd, 32'h1122_3344);
        check_val("status0_waits", 32'(wt), 32'd1);
        check_val("status0_resp", 32'({r0, r1}), 32'd0);
        xfer(BASE + 32'h4, 1'b0, 3'b010, 32'h0, rd, r0, r1, wt);
        check_val("status1_data", rd, 32'h0);
        xfer(BASE + 32'hC, 1'b0, 3'b010, 32'h0, rd, r0, r1, wt);
        check_val("info_data", rd, 32'h0000_0904);
        check_val("info_waits", 32'(wt), 32'd1);
        idle(1);

        // Buffer read ch1 word 1: three wait states with RD_WAIT=2
        clr_mon();
        xfer(BUFB + 32'h804, 1'b0, 3'b010, 32'h0, rd, r0, r1, wt);
        check_val("buf1_data", rd, 32'hBBBB_0001);
        check_val("buf1_waits", 32'(wt), 32'd3);
        check_val("buf1_addr", 32'(eu_buf_addr), 32'd1);
        check_val("buf1_sel", 32'(sel_seen), 32'h2);
        check_val("buf1_resp", 32'({r0, r1}), 32'd0);
        // Last word of the last channel, pipelined behind the previous read
        sel_seen = 4'h0;
        xfer(BUFB + 32'h1FFC, 1'b0, 3'b010, 32'h0, rd, r0, r1, wt);
        check_val("buf3_data", rd, 32'hDDDD_0003);
        check_val("buf3_addr", 32'(eu_buf_addr), 32'h1FF);
        check_val("buf3_sel", 32'(sel_seen), 32'h8);
        idle(1);
        check_val("sel_dropped", 32'(eu_sel), 32'd0);
        check_val("hrdata_hold", hrdata, 32'hDDDD_0003);

        // CLEAR write: zero waits, single pulse of the low NUM_EU bits
        clr_mon();
        xfer(BASE + 32'h8, 1'b1, 3'b010, 32'h0000_00F5, rd, r0, r1, wt);
        check_val("clr_waits", 32'(wt), 32'd0);
        check_val("clr_resp", 32'({r0, r1}), 32'd0);
        idle(3);
        check_val("clr_pulse_cnt", 32'(pulse_cnt), 32'd1);
        check_val("clr_pulse_val", 32'(pulse_or), 32'h5);
        check_val("clr_no_hrdata", hrdata, 32'hDDDD_0003);

        // Write CLEAR then pipelined STATUS0 read
        clr_mon();
        xfer(BASE + 32'h8, 1'b1, 3'b010, 32'h1, rd, r0, r1, wt);
        check_val("wr_rd_wwaits", 32'(wt), 32'd0);
        xfer(BASE + 32'h0, 1'b0, 3'b010, 32'h0, rd, r0, r1, wt);
        check_val("wr_rd_data", rd, 32'h1122_3344);
        check_val("wr_rd_waits", 32'(wt), 32'd1);
        check_val("wr_rd_resp", 32'({r0, r1}), 32'd0);
        idle(2);
        check_val("wr_rd_pulses", 32'(pulse_cnt), 32'd1);
        check_val("wr_rd_pulse", 32'(pulse_or), 32'h1);

        // Back-to-back CLEAR writes: pulses 1 then 2
        clr_mon();
        xfer(BASE + 32'h8, 1'b1, 3'b010, 32'h1, rd, r0, r1, wt);
        xfer(BASE + 32'h8, 1'b1, 3'b010, 32'h2, rd, r0, r1, wt);
        idle(3);
        check_val("wrwr_cnt", 32'(pulse_cnt), 32'd2);
        check_val("wrwr_seq", 32'(pulse_log[7:0]), 32'h12);

        // ERROR responses: two cycles, ready low then high, no pulse
        clr_mon();
        xfer(BUFB + 32'h2000, 1'b0, 3'b010, 32'h0, rd, r0, r1, wt);
        check_val("err_ch4", 32'({r0, r1, 6'(wt)}), 32'hC1);
        idle(1);
        xfer(BASE + 32'h8, 1'b1, 3'b000, 32'hF, rd, r0, r1, wt);
        check_val("err_byte", 32'({r0, r1, 6'(wt)}), 32'hC1);
        idle(1);
        xfer(BASE + 32'h0, 1'b1, 3'b010, 32'hF, rd, r0, r1, wt);
        check_val("err_wr_status", 32'({r0, r1, 6'(wt)}), 32'hC1);
        idle(1);
        xfer(BASE + 32'h8, 1'b0, 3'b010, 32'h0, rd, r0, r1, wt);
        check_val("err_rd_clear", 32'({r0, r1, 6'(wt)}), 32'hC1);
        idle(1);
        xfer(32'h5000_0000, 1'b0, 3'b010, 32'h0, rd, r0, r1, wt);
        check_val("err_outside", 32'({r0, r1, 6'(wt)}), 32'hC1);
        idle(1);
        xfer(BUFB + 32'h4, 1'b1, 3'b010, 32'hF, rd, r0, r1, wt);
        check_val("err_buf_wr", 32'({r0, r1, 6'(wt)}), 32'hC1);
        idle(2);
        check_val("err_no_pulse", 32'(pulse_cnt), 32'd0);
        check_val("err_after_ok", 32'({hresp, hreadyout}), 32'h1);

        // Reset during the buffer-read wait state
        haddr  = BUFB + 32'h804;
        hwrite = 1'b0;
        hsize  = 3'b010;
        hsel   = 1'b1;
        htrans = 2'b10;
        @(posedge clk);
        #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hreset = 1'b1;
        @(posedge clk);
        #1;
        hreset = 1'b0;
        @(negedge clk);
        check_val("mid_rst_ready", 32'(hreadyout), 32'd1);
        check_val("mid_rst_resp", 32'(hresp), 32'd0);
        check_val("mid_rst_hrdata", hrdata, 32'h0);
        check_val("mid_rst_sel", 32'(eu_sel), 32'd0);
        check_val("mid_rst_addr", 32'(eu_buf_addr), 32'd0);
        check_val("mid_rst_clear", 32'(rx_state_clear), 32'd0);
        xfer(BUFB + 32'h1014, 1'b0, 3'b010, 32'h0, rd, r0, r1, wt);
        check_val("post_rst_data", rd, 32'hCCCC_0002);
        check_val("post_rst_waits", 32'(wt), 32'd3);
        check_val("post_rst_addr", 32'(eu_buf_addr), 32'd5);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
